// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the perceptron layer engine.
//   state_t    : controller state encoding
//   acc_width  : accumulator width needed for n_inputs products of dw-bit operands
//   sat_relu   : threshold-gated activation clamped to the unsigned output range
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COLLECT,
    COMPUTE,
    ACT,
    OUTPUT
  } state_t;

  localparam int ACC_MAX_W = 64;

  function automatic int acc_width(input int n_inputs, input int dw);
    return 2 * dw + $clog2(n_inputs) + 2;
  endfunction

  // Returns 0 unless acc strictly exceeds th; otherwise acc clamped to [0, 2^dw-1].
  function automatic logic signed [ACC_MAX_W-1:0] sat_relu(
    input logic signed [ACC_MAX_W-1:0] acc,
    input logic signed [ACC_MAX_W-1:0] th,
    input int                          dw
  );
    logic signed [ACC_MAX_W-1:0] max_val;
    max_val = (64'sd1 <<< dw) - 64'sd1;
    if (acc <= th) return '0;
    if (acc < 0) return '0;
    if (acc > max_val) return max_val;
    return acc;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// One neuron: serial multiply-accumulate plus activation register.
// Ports:
//   clk, rstn            clock / async active-low reset
//   clear                load accumulator with bias (start of a pass)
//   acc_en               acc += zero-ext(x) * signed(w)
//   activate             capture activated value into y
//   bias, th, w          signed parameters for this neuron / current input
//   x                    current unsigned input sample
//   act_value            combinational activation of the current accumulator
//   y                    registered result
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 acc_en,
  input  logic                 activate,
  input  logic signed [DW-1:0] bias,
  input  logic signed [DW-1:0] th,
  input  logic signed [DW-1:0] w,
  input  logic        [DW-1:0] x,
  output logic        [DW-1:0] act_value,
  output logic        [DW-1:0] y
);

  localparam int PW = 2 * DW + 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0]    prod;

  // x is unsigned: a zero MSB makes it a non-negative signed operand.
  assign prod      = PW'($signed({1'b0, x})) * PW'(w);
  assign act_value = DW'(sat_relu(ACC_MAX_W'(acc), ACC_MAX_W'(th), DW));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (clear) acc <= ACC_W'(bias);
      else if (acc_en) acc <= acc + ACC_W'(prod);
      if (activate) y <= act_value;
    end
  end

endmodule

// File: rtl/nn_layer_engine.sv
// Time-multiplexed perceptron layer: N_NEURONS neurons x N_INPUTS inputs.
// Parameters and inputs arrive byte-serially over valid/ready; one MAC per
// neuron per cycle; optional recurrent mode re-runs the layer on its own outputs.
// Ports:
//   clk, rstn                          clock / async active-low reset
//   mode                               0 single pass, 1 recurrent (latched on first input)
//   cfg_valid/cfg_ready/cfg_data       parameter stream (signed words)
//   cfg_done                           full parameter set present
//   in_valid/in_ready/in_data          input vector stream (unsigned words)
//   out_valid/out_ready/out_data       result vector, neuron k at [k*DW +: DW]
//   busy                               high in COMPUTE/ACT/OUTPUT
//
// state   | meaning
// IDLE    | waiting; cfg word restarts a load, input word starts a vector
// LOAD    | receiving parameter words
// COLLECT | receiving remaining input words
// COMPUTE | one MAC per neuron per cycle over inputs 0..N_INPUTS-1
// ACT     | activation; loop back for another recurrent pass or present result
// OUTPUT  | result valid, waiting for consumer
module nn_layer_engine
  import nn_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 4,
  parameter int DW        = 8,
  parameter int PASSES    = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    mode,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic signed [DW-1:0]    cfg_data,
  output logic                    cfg_done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_NEURONS*DW-1:0] out_data,
  output logic                    busy
);

  localparam int ACC_W    = acc_width(N_INPUTS, DW);
  localparam bit RECUR_OK = (N_INPUTS == N_NEURONS);
  localparam int NW       = $clog2(N_NEURONS + 1);
  localparam int CW       = $clog2(N_INPUTS + 2);
  localparam int IW       = $clog2(N_INPUTS + 1);
  localparam int PSW      = $clog2(PASSES + 1);

  if (!RECUR_OK) begin : g_no_recur
    $warning("nn_layer_engine: N_INPUTS != N_NEURONS, mode=1 behaves as single pass");
  end

  state_t state, state_nxt;

  logic                 cfg_fire, in_fire, cfg_last, in_last, cmp_last, do_loop;
  logic                 clear, acc_en, activate;
  logic [NW-1:0]        cfg_n;
  logic [CW-1:0]        cfg_w;
  logic [IW-1:0]        idx;
  logic [PSW-1:0]       pass_cnt;
  logic                 mode_r, cfg_done_r;
  logic signed [DW-1:0] w_mem    [N_NEURONS][N_INPUTS];
  logic signed [DW-1:0] bias_mem [N_NEURONS];
  logic signed [DW-1:0] th_mem   [N_NEURONS];
  logic signed [DW-1:0] w_sel    [N_NEURONS];
  logic [DW-1:0]        x_reg    [N_INPUTS];
  logic [DW-1:0]        fb       [N_INPUTS];
  logic [DW-1:0]        x_sel;
  logic [DW-1:0]        act_value[N_NEURONS];
  logic [DW-1:0]        y        [N_NEURONS];

  // Load pointer and idx are both parked at 0 in IDLE, so the same compares
  // serve the first word accepted in IDLE and the following ones.
  assign cfg_last = (cfg_n == NW'(N_NEURONS - 1)) && (cfg_w == CW'(N_INPUTS + 1));
  assign in_last  = (idx == IW'(N_INPUTS - 1));
  assign cmp_last = (idx == IW'(N_INPUTS - 1));
  assign do_loop  = mode_r && (pass_cnt < PSW'(PASSES));
  assign cfg_done = cfg_done_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    clear     = 1'b0;
    acc_en    = 1'b0;
    activate  = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        in_ready  = cfg_done_r & ~cfg_valid;
        if (cfg_valid) state_nxt = LOAD;
        else if (in_valid && in_ready) begin
          state_nxt = in_last ? COMPUTE : COLLECT;
          clear     = in_last;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid && cfg_last) state_nxt = IDLE;
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_nxt = COMPUTE;
          clear     = 1'b1;
        end
      end
      COMPUTE: begin
        busy   = 1'b1;
        acc_en = 1'b1;
        if (cmp_last) state_nxt = ACT;
      end
      ACT: begin
        busy = 1'b1;
        if (do_loop) begin
          state_nxt = COMPUTE;
          clear     = 1'b1;
        end else begin
          state_nxt = OUTPUT;
          activate  = 1'b1;
        end
      end
      OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    cfg_fire = cfg_valid & cfg_ready;
    in_fire  = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_n      <= '0;
      cfg_w      <= '0;
      idx        <= '0;
      pass_cnt   <= '0;
      mode_r     <= 1'b0;
      cfg_done_r <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) begin
        bias_mem[n] <= '0;
        th_mem[n]   <= '0;
        for (int i = 0; i < N_INPUTS; i++) w_mem[n][i] <= '0;
      end
      for (int i = 0; i < N_INPUTS; i++) x_reg[i] <= '0;
    end else begin
      if (cfg_fire) begin
        for (int n = 0; n < N_NEURONS; n++) begin
          if (cfg_n == NW'(n)) begin
            for (int i = 0; i < N_INPUTS; i++)
              if (cfg_w == CW'(i)) w_mem[n][i] <= cfg_data;
            if (cfg_w == CW'(N_INPUTS)) bias_mem[n] <= cfg_data;
            if (cfg_w == CW'(N_INPUTS + 1)) th_mem[n] <= cfg_data;
          end
        end
        if (state == IDLE) cfg_done_r <= 1'b0;
        if (cfg_last) begin
          cfg_n      <= '0;
          cfg_w      <= '0;
          cfg_done_r <= 1'b1;
        end else if (cfg_w == CW'(N_INPUTS + 1)) begin
          cfg_w <= '0;
          cfg_n <= cfg_n + 1'b1;
        end else begin
          cfg_w <= cfg_w + 1'b1;
        end
      end

      if (in_fire) begin
        for (int i = 0; i < N_INPUTS; i++)
          if (idx == IW'(i)) x_reg[i] <= in_data;
        idx <= in_last ? '0 : idx + 1'b1;
        if (state == IDLE) mode_r <= mode & RECUR_OK;
        if (in_last) pass_cnt <= PSW'(1);
      end

      if (state == COMPUTE) idx <= cmp_last ? '0 : idx + 1'b1;

      if (state == ACT && do_loop) begin
        pass_cnt <= pass_cnt + 1'b1;
        for (int i = 0; i < N_INPUTS; i++) x_reg[i] <= fb[i];
      end
    end
  end

  always_comb begin
    x_sel = '0;
    for (int n = 0; n < N_NEURONS; n++) w_sel[n] = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (idx == IW'(i)) begin
        x_sel = x_reg[i];
        for (int n = 0; n < N_NEURONS; n++) w_sel[n] = w_mem[n][i];
      end
    end
  end

  // Feedback only exists when the layer is square; otherwise mode is forced to 0.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_fb
    if (RECUR_OK) begin : g_on
      assign fb[i] = act_value[i];
    end else begin : g_off
      assign fb[i] = '0;
    end
  end

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_mac
    nn_mac_unit #(
      .DW   (DW),
      .ACC_W(ACC_W)
    ) u_mac (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (clear),
      .acc_en   (acc_en),
      .activate (activate),
      .bias     (bias_mem[k]),
      .th       (th_mem[k]),
      .w        (w_sel[k]),
      .x        (x_sel),
      .act_value(act_value[k]),
      .y        (y[k])
    );
    assign out_data[k*DW +: DW] = y[k];
  end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Scoreboard bench for nn_layer_engine (4 neurons x 4 inputs, 8-bit, 2 passes).
module tb_nn_layer_engine;

  localparam int NN     = 4;
  localparam int NI     = 4;
  localparam int DW     = 8;
  localparam int PASSES = 2;
  localparam int NWORDS = NN * (NI + 2);

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             mode = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [DW-1:0]    cfg_data = '0;
  logic             cfg_done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [NN*DW-1:0] out_data;
  logic             busy;

  nn_layer_engine #(
    .N_NEURONS(NN),
    .N_INPUTS (NI),
    .DW       (DW),
    .PASSES   (PASSES)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mode     (mode),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .cfg_done (cfg_done),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   w_m[NN][NI];
  int   b_m[NN];
  int   th_m[NN];
  exp_t exp_q[$];
  int   cyc = 0;
  int   last_in = 0;
  bit   prev_v = 1'b0;
  bit   rand_ready = 1'b0;
  bit   force_ready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: layer evaluated with plain integer arithmetic, repeated per pass.
  function automatic logic [31:0] model(input int x[NI], input bit md);
    int xv[NI];
    int yv[NN];
    int acc;
    int np;
    logic [31:0] r;
    xv = x;
    np = md ? PASSES : 1;
    for (int p = 0; p < np; p++) begin
      for (int n = 0; n < NN; n++) begin
        acc = b_m[n];
        for (int i = 0; i < NI; i++) acc += xv[i] * w_m[n][i];
        if (acc > th_m[n]) yv[n] = (acc > 255) ? 255 : ((acc < 0) ? 0 : acc);
        else yv[n] = 0;
      end
      for (int i = 0; i < NI; i++) xv[i] = yv[i];
    end
    r = '0;
    for (int n = 0; n < NN; n++) r[n*8 +: 8] = 8'(yv[n]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rstn && in_valid && in_ready) last_in <= cyc + 1;
    cyc <= cyc + 1;
  end

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rstn) prev_v = 1'b0;
    else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h required=no_output", out_data);
        end else begin
          if (!prev_v) check("latency", 64'(cyc - last_in), 64'(exp_q[0].lat));
          check("out_data", 64'(out_data), 64'(exp_q[0].data));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end
  end

  task automatic send_cfg(input logic [7:0] d);
    int t;
    t = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    do begin
      @(negedge clk);
      t++;
    end while (!cfg_ready && t < 200);
    if (!cfg_ready) begin
      checks++;
      failures++;
      $display("FAIL cfg_timeout actual=no_ready required=ready");
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_in(input logic [7:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_timeout actual=no_ready required=ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] cfg_word(input int j);
    int n, r;
    n = j / (NI + 2);
    r = j % (NI + 2);
    if (r < NI) return 8'(w_m[n][r]);
    if (r == NI) return 8'(b_m[n]);
    return 8'(th_m[n]);
  endfunction

  task automatic load_params(input int start);
    for (int j = start; j < NWORDS; j++) send_cfg(cfg_word(j));
    check("cfg_done_after_load", 64'(cfg_done), 64'(1));
  endtask

  task automatic send_vec(input int x[NI], input bit md, input bit expect_out);
    exp_t e;
    if (expect_out) begin
      e.data = model(x, md);
      e.lat  = (NI + 1) * (md ? PASSES : 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < NI; i++) begin
      mode = (i == 0) ? md : 1'($urandom_range(0, 1));
      send_in(8'(x[i]));
      mode = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_uniform(input int w, input int b, input int th);
    for (int n = 0; n < NN; n++) begin
      b_m[n]  = b;
      th_m[n] = th;
      for (int i = 0; i < NI; i++) w_m[n][i] = w;
    end
  endtask

  initial begin
    int t;
    int xv[NI];

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_cfg_done", 64'(cfg_done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_cfg_ready", 64'(cfg_ready), 64'(1));

    // Basic
    set_uniform(1, 0, 0);
    load_params(0);
    send_vec('{10, 20, 30, 40}, 1'b0, 1'b1);
    wait_drain();

    // Saturation / sign
    set_uniform(0, 0, 0);
    for (int i = 0; i < NI; i++) begin
      w_m[0][i] = 127;
      w_m[1][i] = -1;
    end
    b_m[2]    = -128;
    w_m[3][3] = 1;
    b_m[3]    = -55;
    th_m[3]   = -128;
    load_params(0);
    send_vec('{255, 255, 255, 255}, 1'b0, 1'b1);
    wait_drain();

    // Threshold edge
    set_uniform(1, 0, 100);
    load_params(0);
    send_vec('{25, 25, 25, 25}, 1'b0, 1'b1);
    send_vec('{25, 25, 25, 26}, 1'b0, 1'b1);
    wait_drain();

    // Recurrent: identity weights, bias 1
    set_uniform(0, 1, 0);
    for (int n = 0; n < NN; n++) w_m[n][n] = 1;
    load_params(0);
    send_vec('{5, 6, 7, 8}, 1'b1, 1'b1);
    wait_drain();

    // Backpressure
    force_ready = 1'b0;
    @(posedge clk);
    #1;
    send_vec('{9, 1, 4, 2}, 1'b0, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid_seen", 64'(out_valid), 64'(1));
    in_valid = 1'b1;
    in_data  = 8'd77;
    repeat (20) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    in_valid    = 1'b0;
    force_ready = 1'b1;
    wait_drain();

    // Priority: cfg and in both valid in IDLE with a complete parameter set
    for (int n = 0; n < NN; n++) begin
      b_m[n]  = int'($urandom_range(0, 40)) - 20;
      th_m[n] = int'($urandom_range(0, 60)) - 30;
      for (int i = 0; i < NI; i++) w_m[n][i] = int'($urandom_range(0, 255)) - 128;
    end
    cfg_valid = 1'b1;
    cfg_data  = cfg_word(0);
    in_valid  = 1'b1;
    in_data   = 8'd9;
    @(negedge clk);
    check("prio_in_ready", 64'(in_ready), 64'(0));
    check("prio_cfg_ready", 64'(cfg_ready), 64'(1));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    check("prio_cfg_done_cleared", 64'(cfg_done), 64'(0));
    check("prio_not_busy", 64'(busy), 64'(0));
    load_params(1);
    send_vec('{200, 17, 96, 3}, 1'b0, 1'b1);
    wait_drain();

    // Randomized parameter sets, vectors, modes and consumer backpressure
    rand_ready = 1'b1;
    repeat (6) begin
      for (int n = 0; n < NN; n++) begin
        b_m[n]  = int'($urandom_range(0, 255)) - 128;
        th_m[n] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < NI; i++) w_m[n][i] = int'($urandom_range(0, 255)) - 128;
      end
      if ($urandom_range(0, 1) == 1)
        for (int n = 0; n < NN; n++)
          for (int i = 0; i < NI; i++) w_m[n][i] = int'($urandom_range(0, 6)) - 2;
      load_params(0);
      repeat (3) begin
        for (int i = 0; i < NI; i++) xv[i] = int'($urandom_range(0, 255));
        send_vec(xv, 1'($urandom_range(0, 1)), 1'b1);
      end
      wait_drain();
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset during COMPUTE
    set_uniform(1, 0, 0);
    load_params(0);
    send_vec('{10, 20, 30, 40}, 1'b0, 1'b1);
    wait_drain();
    send_vec('{1, 1, 1, 1}, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'(1));
    check("mid_cfg_ready", 64'(cfg_ready), 64'(0));
    #2;
    rstn = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_data", 64'(out_data), 64'(0));
    check("arst_cfg_done", 64'(cfg_done), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd3;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    load_params(0);
    send_vec('{1, 2, 3, 4}, 1'b0, 1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
